jtag_tap_sync: RTL and testbench
================================

JTAG_TAP_SYNC -- requirements
Module: jtag_tap_sync

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h0000_0001, 32-bit value captured by the IDCODE register.
REQ-002 SHALL have parameter USER_W, default 32, width of the user data register.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port jtags  jtagif.slave  -  tck/tms/tdi/trst inputs (trst active-low), tdo output.
REQ-006 SHALL have port tap_state  output  4  current TAP state encoding (IEEE 1149.1 order: TLR=0 ... UPDATE_IR=15).
REQ-007 SHALL have port ir  output  4  current instruction register.
REQ-008 SHALL have port user_din  input  USER_W  parallel value loaded on Capture-DR with USER selected.
REQ-009 SHALL have port user_dout  output  USER_W  value latched on Update-DR with USER selected.
REQ-010 SHALL have port user_upd  output  1  one-clk pulse when user_dout is written.

Function
REQ-011 SHALL synchronise tck, tms, tdi, trst through 2 flops each; trst synchroniser resets to 1, others to 0.
REQ-012 SHALL generate rise pulse when synced tck=1 and previous synced tck=0; fall pulse on the opposite; at most one per clk.
REQ-013 SHALL advance the 16-state TAP FSM on the clk after a rise pulse, using synced tms, per IEEE 1149.1 transitions.
REQ-014 SHALL force the FSM to TLR while synced trst=0; trst low overrides a coincident rise pulse.
REQ-015 SHALL in TLR load ir with IDCODE opcode 4'h1 (BYPASS 4'hF if REQ-029 disabled).
REQ-016 SHALL on rise in CAPTURE_IR load IR shift reg with 4'b0001; in SHIFT_IR shift right, tdi into MSB.
REQ-017 SHALL on rise in UPDATE_IR copy IR shift reg to ir.
REQ-018 SHALL decode ir: 4'h1 IDCODE (32 bit), 4'h8 USER (USER_W bit), all others BYPASS (1 bit).
REQ-019 SHALL on rise in CAPTURE_DR load selected DR: IDCODE param, user_din, or 0 for BYPASS.
REQ-020 SHALL on rise in SHIFT_DR shift selected DR right, tdi into MSB of that register's width.
REQ-021 SHALL on rise in UPDATE_DR with USER selected load user_dout from shift reg and pulse user_upd same clk.
REQ-022 SHALL on fall pulse drive tdo from shift reg LSB when FSM in SHIFT_IR/SHIFT_DR, else 0; tdo held between fall pulses.
REQ-023 SHALL tolerate tck high/low phases of >=3 clk each; faster tck is unsupported.
REQ-024 SHALL hold all state when no rise/fall pulse occurs.

Reset
REQ-025 SHALL on rst=1 set tap_state=TLR(0), ir per REQ-015, shift regs=0, tdo=0, user_dout=0, user_upd=0.
REQ-026 SHALL reset synchronisers and edge history per REQ-011 so no spurious edge follows rst release.
REQ-027 SHALL abort any in-progress shift when rst asserts mid-scan; no update occurs.
REQ-028 SHALL treat trst=0 as TAP reset only; user_dout is preserved by trst.

Configuration
REQ-029 SHALL with JTAG_TAP_IDCODE_EN defined implement the IDCODE register and reset ir to 4'h1.
REQ-030 SHALL without JTAG_TAP_IDCODE_EN treat 4'h1 as BYPASS, reset ir to 4'hF, and omit the 32-bit IDCODE register.

Verification
REQ-031 SHALL test: rst, 5 tck with tms=1 -> tap_state=0, ir=4'h1 (macro on) or 4'hF (off).
REQ-032 SHALL test: TLR->SHIFT_DR, 32 tck, macro on, IDCODE=32'h1BA0_C001 -> tdo bits LSB-first equal 32'h1BA0_C001.
REQ-033 SHALL test: load ir=4'hF, shift 8'hA5 through DR -> tdo returns 8'hA5 delayed one bit, first bit 0.
REQ-034 SHALL test: ir=4'h8, user_din=32'hDEAD_BEEF, shift in 32'h1234_5678 -> tdo=32'hDEAD_BEEF, user_dout=32'h1234_5678, one user_upd pulse.
REQ-035 SHALL test: trst=0 mid SHIFT_DR -> tap_state=0 within 3 clk, user_dout unchanged, no user_upd.
REQ-036 SHALL test: rst pulse mid SHIFT_IR -> ir=reset value, tdo=0, no update after release.

Source files
------------

// File: rtl/jtag_tap_sync_if.sv
// JTAG pin bundle: tck/tms/tdi/trst toward the TAP, tdo back from it.
// trst is active-low.
interface jtagif;
  logic tck;
  logic tms;
  logic tdi;
  logic trst;
  logic tdo;

  modport master (output tck, output tms, output tdi, output trst, input tdo);
  modport slave  (input tck, input tms, input tdi, input trst, output tdo);
endinterface

// File: rtl/jtag_tap_sync.sv
// IEEE 1149.1 TAP controller oversampling the JTAG pins in the clk domain.
// Define JTAG_TAP_IDCODE_EN to include the 32-bit IDCODE data register.
module jtag_tap_sync #(
  parameter logic [31:0] IDCODE = 32'h0000_0001,
  parameter int          USER_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  jtagif.slave              jtags,
  output logic [3:0]        tap_state,
  output logic [3:0]        ir,
  input  logic [USER_W-1:0] user_din,
  output logic [USER_W-1:0] user_dout,
  output logic              user_upd
);

  typedef enum logic [3:0] {
    TLR        = 4'd0,  RTI       = 4'd1,  SELECT_DR = 4'd2,  CAPTURE_DR = 4'd3,
    SHIFT_DR   = 4'd4,  EXIT1_DR  = 4'd5,  PAUSE_DR  = 4'd6,  EXIT2_DR   = 4'd7,
    UPDATE_DR  = 4'd8,  SELECT_IR = 4'd9,  CAPTURE_IR = 4'd10, SHIFT_IR  = 4'd11,
    EXIT1_IR   = 4'd12, PAUSE_IR  = 4'd13, EXIT2_IR  = 4'd14, UPDATE_IR  = 4'd15
  } state_t;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] IR_RST = 4'h1;
`else
  localparam logic [3:0] IR_RST = 4'hF;
`endif

  logic r_tck_s1, r_tck_s2, r_tck_d;
  logic r_tms_s1, r_tms_s2;
  logic r_tdi_s1, r_tdi_s2;
  logic r_trst_s1, r_trst_s2;

  state_t r_state, w_next;
  logic   w_cap_ir, w_shift_ir, w_upd_ir, w_cap_dr, w_shift_dr, w_upd_dr;
  logic   w_sel_user, w_sel_id, w_dr_lsb;

  logic [3:0]        r_ir, r_ir_sr;
  logic              r_byp;
  logic [USER_W-1:0] r_user_sr, r_user_dout;
  logic              r_user_upd, r_tdo;
`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0]       r_idcode_sr;
`endif

  logic w_rise, w_fall, w_trst_n, w_step;

  // Two-flop synchronisers plus tck history; trst idles released (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_s1  <= 1'b0; r_tck_s2  <= 1'b0; r_tck_d <= 1'b0;
      r_tms_s1  <= 1'b0; r_tms_s2  <= 1'b0;
      r_tdi_s1  <= 1'b0; r_tdi_s2  <= 1'b0;
      r_trst_s1 <= 1'b1; r_trst_s2 <= 1'b1;
    end else begin
      r_tck_s1  <= jtags.tck;  r_tck_s2  <= r_tck_s1; r_tck_d <= r_tck_s2;
      r_tms_s1  <= jtags.tms;  r_tms_s2  <= r_tms_s1;
      r_tdi_s1  <= jtags.tdi;  r_tdi_s2  <= r_tdi_s1;
      r_trst_s1 <= jtags.trst; r_trst_s2 <= r_trst_s1;
    end
  end

  assign w_rise   = r_tck_s2 & ~r_tck_d;
  assign w_fall   = ~r_tck_s2 & r_tck_d;
  assign w_trst_n = r_trst_s2;
  assign w_step   = w_rise & w_trst_n;

  // TAP state register; a low trst wins over any coincident tck rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TLR;
    end else if (!w_trst_n) begin
      r_state <= TLR;
    end else if (w_rise) begin
      r_state <= w_next;
    end else begin
      r_state <= r_state;
    end
  end

  // IEEE 1149.1 next-state function of the sampled tms.
  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:        w_next = r_tms_s2 ? TLR       : RTI;
      RTI:        w_next = r_tms_s2 ? SELECT_DR : RTI;
      SELECT_DR:  w_next = r_tms_s2 ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: w_next = r_tms_s2 ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   w_next = r_tms_s2 ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   w_next = r_tms_s2 ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   w_next = r_tms_s2 ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   w_next = r_tms_s2 ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  w_next = r_tms_s2 ? SELECT_DR : RTI;
      SELECT_IR:  w_next = r_tms_s2 ? TLR       : CAPTURE_IR;
      CAPTURE_IR: w_next = r_tms_s2 ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   w_next = r_tms_s2 ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   w_next = r_tms_s2 ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   w_next = r_tms_s2 ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   w_next = r_tms_s2 ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  w_next = r_tms_s2 ? SELECT_DR : RTI;
      default:    w_next = TLR;
    endcase
  end

  // State decode into register actions, plus instruction decode.
  always_comb begin
    w_cap_ir   = 1'b0;
    w_shift_ir = 1'b0;
    w_upd_ir   = 1'b0;
    w_cap_dr   = 1'b0;
    w_shift_dr = 1'b0;
    w_upd_dr   = 1'b0;
    case (r_state)
      CAPTURE_IR: w_cap_ir   = 1'b1;
      SHIFT_IR:   w_shift_ir = 1'b1;
      UPDATE_IR:  w_upd_ir   = 1'b1;
      CAPTURE_DR: w_cap_dr   = 1'b1;
      SHIFT_DR:   w_shift_dr = 1'b1;
      UPDATE_DR:  w_upd_dr   = 1'b1;
      default:    w_cap_ir   = 1'b0;
    endcase
    w_sel_user = (r_ir == 4'h8);
`ifdef JTAG_TAP_IDCODE_EN
    w_sel_id   = (r_ir == 4'h1);
`else
    w_sel_id   = 1'b0;
`endif
    if (w_sel_user) begin
      w_dr_lsb = r_user_sr[0];
`ifdef JTAG_TAP_IDCODE_EN
    end else if (w_sel_id) begin
      w_dr_lsb = r_idcode_sr[0];
`endif
    end else begin
      w_dr_lsb = r_byp;
    end
  end

  // Instruction path: TLR (or trst) restores the default opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir    <= IR_RST;
      r_ir_sr <= 4'h0;
    end else begin
      if (!w_trst_n || r_state == TLR) begin
        r_ir <= IR_RST;
      end else if (w_step && w_upd_ir) begin
        r_ir <= r_ir_sr;
      end
      if (w_step && w_cap_ir) begin
        r_ir_sr <= 4'b0001;
      end else if (w_step && w_shift_ir) begin
        r_ir_sr <= {r_tdi_s2, r_ir_sr[3:1]};
      end
    end
  end

  // Data registers, user update strobe and tdo (changes only on tck fall).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byp       <= 1'b0;
      r_user_sr   <= '0;
      r_user_dout <= '0;
      r_user_upd  <= 1'b0;
      r_tdo       <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      r_idcode_sr <= 32'h0;
`endif
    end else begin
      r_user_upd <= 1'b0;
      if (w_step && w_cap_dr) begin
        r_byp <= 1'b0;
        if (w_sel_user) r_user_sr <= user_din;
`ifdef JTAG_TAP_IDCODE_EN
        if (w_sel_id) r_idcode_sr <= IDCODE;
`endif
      end else if (w_step && w_shift_dr) begin
        if (w_sel_user) begin
          r_user_sr <= {r_tdi_s2, r_user_sr[USER_W-1:1]};
`ifdef JTAG_TAP_IDCODE_EN
        end else if (w_sel_id) begin
          r_idcode_sr <= {r_tdi_s2, r_idcode_sr[31:1]};
`endif
        end else begin
          r_byp <= r_tdi_s2;
        end
      end
      if (w_step && w_upd_dr && w_sel_user) begin
        r_user_dout <= r_user_sr;
        r_user_upd  <= 1'b1;
      end
      if (w_fall) begin
        r_tdo <= w_shift_ir ? r_ir_sr[0] : (w_shift_dr ? w_dr_lsb : 1'b0);
      end
    end
  end

  assign tap_state = r_state;
  assign ir        = r_ir;
  assign user_dout = r_user_dout;
  assign user_upd  = r_user_upd;
  assign jtags.tdo = r_tdo;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Self-checking bench for jtag_tap_sync: directed scans plus randomized
// IR/DR scans compared against a bit-stream model of the data registers.
module tb_jtag_tap_sync;
  localparam logic [31:0] IDC = 32'h1BA0_C001;
  localparam int          UW  = 32;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0]  IR_RST = 4'h1;
  localparam bit          ID_EN  = 1'b1;
`else
  localparam logic [3:0]  IR_RST = 4'hF;
  localparam bit          ID_EN  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    tap_state, ir;
  logic [UW-1:0] user_din, user_dout;
  logic          user_upd;
  int            checks = 0;
  int            errors = 0;
  int            upd_cnt = 0;
  logic [UW-1:0] ref_dout;

  jtagif jif();

  jtag_tap_sync #(.IDCODE(IDC), .USER_W(UW)) dut (
    .clk(clk), .rst(rst), .jtags(jif.slave), .tap_state(tap_state), .ir(ir),
    .user_din(user_din), .user_dout(user_dout), .user_upd(user_upd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (user_upd === 1'b1) upd_cnt++;

  // Model: which data register an opcode selects, its width and captured value.
  function automatic int dr_width(input logic [3:0] v);
    if (v == 4'h8) return UW;
    if (v == 4'h1 && ID_EN) return 32;
    return 1;
  endfunction

  function automatic logic [63:0] dr_capture(input logic [3:0] v, input logic [UW-1:0] din);
    if (v == 4'h8) return {32'h0, din};
    if (v == 4'h1 && ID_EN) return {32'h0, IDC};
    return 64'h0;
  endfunction

  // A W-bit shift register emits its captured bits first, then the bits fed in.
  function automatic logic [63:0] stream_out(input int w, input logic [63:0] cap,
                                             input logic [63:0] d, input int n);
    logic [63:0] r = 64'h0;
    for (int k = 0; k < n; k++) r[k] = (k < w) ? cap[k] : d[k-w];
    return r;
  endfunction

  function automatic logic [63:0] last_bits(input int w, input logic [63:0] d, input int n);
    logic [63:0] r = 64'h0;
    for (int i = 0; i < w; i++) r[i] = d[n-w+i];
    return r;
  endfunction

  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    @(negedge clk);
    jif.tck = 1'b0; jif.tms = tms_v; jif.tdi = tdi_v;
    repeat (4) @(negedge clk);
    tdo_v = jif.tdo;
    jif.tck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // From RTI: scan 4 bits into IR and return to RTI.
  task automatic shift_ir(input logic [3:0] v, output logic [3:0] q);
    logic b;
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, v[i], b);
      q[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
  endtask

  // From RTI: scan n bits through the selected DR and return to RTI.
  task automatic shift_dr(input int n, input logic [63:0] d, output logic [63:0] q);
    logic b;
    q = 64'h0;
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, d[i], b);
      q[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; jif.tck = 1'b0; jif.tms = 1'b0; jif.tdi = 1'b0; jif.trst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ref_dout = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic b;
    do_reset();
    checks++; if (tap_state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", tap_state); end
    checks++; if (ir !== IR_RST) begin errors++; $display("FAIL rst_ir got %h want %h", ir, IR_RST); end
    checks++; if (jif.tdo !== 1'b0) begin errors++; $display("FAIL rst_tdo got %b want 0", jif.tdo); end
    checks++; if (user_dout !== '0 || user_upd !== 1'b0) begin errors++; $display("FAIL rst_user got %h/%b want 0/0", user_dout, user_upd); end
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
    checks++; if (tap_state !== 4'd0 || ir !== IR_RST) begin errors++; $display("FAIL tms5_tlr got %0d/%h want 0/%h", tap_state, ir, IR_RST); end
    tck_cycle(1'b0, 1'b0, b);
    checks++; if (tap_state !== 4'd1) begin errors++; $display("FAIL to_rti got %0d want 1", tap_state); end
  endtask

  task automatic test_idcode();
    logic [63:0] d, q, e;
    d = {32'h0, $urandom};
    shift_dr(32, d, q);
    e = stream_out(dr_width(IR_RST), dr_capture(IR_RST, user_din), d, 32);
    checks++; if (q !== e) begin errors++; $display("FAIL idcode_tdo got %h want %h", q[31:0], e[31:0]); end
    if (ID_EN) begin
      checks++; if (q[31:0] !== 32'h1BA0_C001) begin errors++; $display("FAIL idcode_val got %h want 1ba0c001", q[31:0]); end
    end
    checks++; if (user_dout !== ref_dout) begin errors++; $display("FAIL idcode_dout got %h want %h", user_dout, ref_dout); end
  endtask

  task automatic test_bypass();
    logic [3:0]  ib;
    logic [63:0] q;
    shift_ir(4'hF, ib);
    checks++; if (ir !== 4'hF) begin errors++; $display("FAIL byp_ir got %h want f", ir); end
    checks++; if (ib !== 4'b0001) begin errors++; $display("FAIL byp_ir_tdo got %b want 0001", ib); end
    shift_dr(8, 64'hA5, q);
    checks++; if (q !== 64'h4A) begin errors++; $display("FAIL byp_tdo got %h want 4a", q); end
  endtask

  task automatic test_user();
    logic [3:0]  ib;
    logic [63:0] q;
    int          c0;
    shift_ir(4'h8, ib);
    checks++; if (ir !== 4'h8) begin errors++; $display("FAIL user_ir got %h want 8", ir); end
    user_din = 32'hDEAD_BEEF;
    c0 = upd_cnt;
    shift_dr(32, 64'h1234_5678, q);
    ref_dout = 32'h1234_5678;
    checks++; if (q !== 64'hDEAD_BEEF) begin errors++; $display("FAIL user_tdo got %h want deadbeef", q); end
    checks++; if (user_dout !== 32'h1234_5678) begin errors++; $display("FAIL user_dout got %h want 12345678", user_dout); end
    checks++; if (upd_cnt !== c0 + 1) begin errors++; $display("FAIL user_upd got %0d want %0d", upd_cnt - c0, 1); end
  endtask

  task automatic test_random();
    logic [3:0]  v, ib;
    logic [63:0] d, q, e, lb;
    int          w, n, c0;
    for (int it = 0; it < 8; it++) begin
      case (it % 4)
        0:       v = 4'h8;
        1:       v = 4'h1;
        2:       v = 4'hF;
        default: v = 4'($urandom_range(0, 15));
      endcase
      user_din = $urandom;
      w = dr_width(v);
      n = w + int'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      shift_ir(v, ib);
      checks++; if (ir !== v || ib !== 4'b0001) begin errors++; $display("FAIL rnd_ir it%0d got %h/%b want %h/0001", it, ir, ib, v); end
      c0 = upd_cnt;
      shift_dr(n, d, q);
      e = stream_out(w, dr_capture(v, user_din), d, n);
      if (v == 4'h8) begin
        lb = last_bits(w, d, n);
        ref_dout = lb[UW-1:0];
      end
      checks++; if (q !== e) begin errors++; $display("FAIL rnd_tdo it%0d got %h want %h", it, q, e); end
      checks++; if (user_dout !== ref_dout) begin errors++; $display("FAIL rnd_dout it%0d got %h want %h", it, user_dout, ref_dout); end
      checks++; if (upd_cnt !== c0 + ((v == 4'h8) ? 1 : 0)) begin errors++; $display("FAIL rnd_upd it%0d got %0d pulses", it, upd_cnt - c0); end
    end
  endtask

  task automatic test_trst();
    logic [3:0] ib;
    logic       b;
    int         c0;
    shift_ir(4'h8, ib);
    user_din = $urandom;
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom_range(0, 1)), b);
    checks++; if (tap_state !== 4'd4) begin errors++; $display("FAIL trst_pre got %0d want 4", tap_state); end
    c0 = upd_cnt;
    @(negedge clk);
    jif.trst = 1'b0;
    for (int i = 0; i < 3 && tap_state !== 4'd0; i++) @(negedge clk);
    checks++; if (tap_state !== 4'd0) begin errors++; $display("FAIL trst_tlr got %0d want 0 within 3 clk", tap_state); end
    repeat (2) @(negedge clk);
    checks++; if (ir !== IR_RST) begin errors++; $display("FAIL trst_ir got %h want %h", ir, IR_RST); end
    jif.trst = 1'b1;
    repeat (4) @(negedge clk);
    tck_cycle(1'b0, 1'b0, b);
    checks++; if (user_dout !== ref_dout || upd_cnt !== c0) begin errors++; $display("FAIL trst_user got %h/%0d want %h/0", user_dout, upd_cnt - c0, ref_dout); end
  endtask

  task automatic test_rst_mid_ir();
    logic b;
    int   c0;
    tck_cycle(1'b1, 1'b0, b); tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b); tck_cycle(1'b0, 1'b1, b);
    checks++; if (tap_state !== 4'd11) begin errors++; $display("FAIL rstir_pre got %0d want 11", tap_state); end
    c0 = upd_cnt;
    do_reset();
    checks++; if (tap_state !== 4'd0 || ir !== IR_RST || jif.tdo !== 1'b0) begin errors++; $display("FAIL rstir_post got %0d/%h/%b want 0/%h/0", tap_state, ir, jif.tdo, IR_RST); end
    for (int i = 0; i < 3; i++) tck_cycle(1'b1, 1'b0, b);
    checks++; if (ir !== IR_RST || jif.tdo !== 1'b0 || tap_state !== 4'd0) begin errors++; $display("FAIL rstir_hold got %h/%b/%0d want %h/0/0", ir, jif.tdo, tap_state, IR_RST); end
    checks++; if (user_dout !== '0 || upd_cnt !== c0) begin errors++; $display("FAIL rstir_user got %h/%0d want 0/0", user_dout, upd_cnt - c0); end
  endtask

  initial begin
    rst = 1'b1; jif.tck = 1'b0; jif.tms = 1'b0; jif.tdi = 1'b0; jif.trst = 1'b1;
    user_din = '0; ref_dout = '0;
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_random();
    test_trst();
    test_rst_mid_ir();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
